bcd_seq_converter: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Replaces the combinational divide/modulo digit extraction that feeds the icon/HUD display path for the score and speed readouts.
- One instance per displayed value. Uses a start/busy/done handshake.
- Registered digits include saturation on overflow and a leading-zero blanking mask for the display.

---
 rtl/bcd_seq_converter.sv | 105 ++++++++++
 tb/tb_bcd_seq_converter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Uses a start/busy/done handshake and produces saturated digits plus a leading-zero mask.
module bcd_seq_converter #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned       AccW     = 4 * DIGITS;
  localparam int unsigned       CntW     = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0]   LastCnt  = CntW'(BIN_W - 1);
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  sr_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              ovf_q;

  logic [AccW-1:0]   acc_adj;
  logic [DIGITS-1:0] blank_calc;
  logic              zero_run;

  // Per-nibble add-3 correction; nibbles never carry into each other.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run      = zero_run & (acc_q[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      blank    <= BlankRst;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sr_q    <= bin_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q <= {acc_adj[AccW-2:0], sr_q[BIN_W-1]};
          sr_q  <= sr_q << 1;
          // A bit leaving the top digit means the value no longer fits in DIGITS digits.
          ovf_q <= ovf_q | acc_adj[AccW-1];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= ovf_q;
          bcd_out  <= ovf_q ? {DIGITS{4'h9}} : acc_q;
          blank    <= ovf_q ? '0 : blank_calc;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: a 20-bit/6-digit instance and an 8-bit/3-digit
// instance, checked with immediate assertions against hand-computed values.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        b_start;
  logic [19:0] b_bin;
  logic        b_busy;
  logic        b_done;
  logic [23:0] b_bcd;
  logic        b_ovf;
  logic [5:0]  b_blank;

  logic        s_start;
  logic [7:0]  s_bin;
  logic        s_busy;
  logic        s_done;
  logic [11:0] s_bcd;
  logic        s_ovf;
  logic [2:0]  s_blank;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_seq_converter #(.BIN_W(20), .DIGITS(6)) u_big (
    .clk      (clk),
    .reset    (reset),
    .start    (b_start),
    .bin_in   (b_bin),
    .busy     (b_busy),
    .done     (b_done),
    .bcd_out  (b_bcd),
    .overflow (b_ovf),
    .blank    (b_blank)
  );

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_small (
    .clk      (clk),
    .reset    (reset),
    .start    (s_start),
    .bin_in   (s_bin),
    .busy     (s_busy),
    .done     (s_done),
    .bcd_out  (s_bcd),
    .overflow (s_ovf),
    .blank    (s_blank)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion on the wide instance and check latency and result.
  task automatic conv_big(input logic [19:0] v, input logic [23:0] exp_bcd,
                          input logic exp_ovf, input logic [5:0] exp_blank);
    int edges;
    b_bin   = v;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    edges   = 1;
    while (b_done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    chk($sformatf("big_lat_%0d", v), edges, 22);
    chk($sformatf("big_bcd_%0d", v), b_bcd, exp_bcd);
    chk($sformatf("big_ovf_%0d", v), b_ovf, exp_ovf);
    chk($sformatf("big_blank_%0d", v), b_blank, exp_blank);
  endtask

  // Narrow instance, reference digits from /10 and %10.
  task automatic conv_small(input int v);
    int          edges;
    int          d2, d1, d0;
    logic [11:0] exp_bcd;
    logic [2:0]  exp_blank;
    d2        = v / 100;
    d1        = (v / 10) % 10;
    d0        = v % 10;
    exp_bcd   = 12'(d2 * 256 + d1 * 16 + d0);
    exp_blank = {d2 == 0, d2 == 0 && d1 == 0, 1'b0};
    s_bin     = 8'(v);
    s_start   = 1'b1;
    tick();
    s_start   = 1'b0;
    edges     = 1;
    while (s_done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    chk($sformatf("small_lat_%0d", v), edges, 10);
    chk($sformatf("small_bcd_%0d", v), s_bcd, exp_bcd);
    chk($sformatf("small_ovf_%0d", v), s_ovf, 1'b0);
    chk($sformatf("small_blank_%0d", v), s_blank, exp_blank);
  endtask

  initial begin
    int edges, busy_lo, extra, t, c1, c2;
    reset   = 1'b1;
    b_start = 1'b0;
    b_bin   = '0;
    s_start = 1'b0;
    s_bin   = '0;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_busy", b_busy, 1'b0);
    chk("rst_done", b_done, 1'b0);
    chk("rst_bcd", b_bcd, 24'h0);
    chk("rst_ovf", b_ovf, 1'b0);
    chk("rst_blank", b_blank, 6'b111110);
    chk("rst_small_blank", s_blank, 3'b110);

    conv_big(20'd0, 24'h000000, 1'b0, 6'b111110);
    conv_big(20'd123456, 24'h123456, 1'b0, 6'b000000);
    conv_big(20'd999999, 24'h999999, 1'b0, 6'b000000);
    conv_big(20'hFFFFF, 24'h999999, 1'b1, 6'b000000);
    conv_big(20'd42, 24'h000042, 1'b0, 6'b111100);
    conv_big(20'd1000000, 24'h999999, 1'b1, 6'b000000);
    conv_big(20'd100, 24'h000100, 1'b0, 6'b111000);

    // Second start during busy must be ignored.
    b_bin   = 20'd500;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    busy_lo = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (b_busy !== 1'b1) busy_lo++;
    end
    b_bin   = 20'd77;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_bin   = 20'd0;
    edges   = 6;
    while (b_done !== 1'b1 && edges < 60) begin
      if (b_busy !== 1'b1) busy_lo++;
      tick();
      edges++;
    end
    chk("ign_lat", edges, 22);
    chk("ign_busy_gap", busy_lo, 0);
    chk("ign_bcd", b_bcd, 24'h000500);
    chk("ign_blank", b_blank, 6'b111000);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (b_done === 1'b1) extra++;
    end
    chk("ign_single_done", extra, 0);
    chk("ign_idle_busy", b_busy, 1'b0);

    // Start held high: back-to-back conversions.
    b_bin   = 20'd7;
    b_start = 1'b1;
    tick();
    t = 0;
    while (b_done !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    c1 = cyc;
    tick();
    chk("b2b_done_not_twice", b_done, 1'b0);
    t = 0;
    while (b_done !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    c2      = cyc;
    b_start = 1'b0;
    chk("b2b_spacing", c2 - c1, 22);
    chk("b2b_bcd", b_bcd, 24'h000007);
    chk("b2b_blank", b_blank, 6'b111110);

    // Reset mid-conversion aborts without a done pulse.
    b_bin   = 20'd321;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", b_busy, 1'b0);
    chk("abort_done", b_done, 1'b0);
    chk("abort_bcd", b_bcd, 24'h0);
    chk("abort_ovf", b_ovf, 1'b0);
    chk("abort_blank", b_blank, 6'b111110);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (b_done === 1'b1) extra++;
    end
    chk("abort_no_done", extra, 0);
    conv_big(20'd654321, 24'h654321, 1'b0, 6'b000000);

    // Narrow instance: directed points then full sweep.
    conv_small(255);
    chk("small_255", s_bcd, 12'h255);
    conv_small(7);
    chk("small_7", s_bcd, 12'h007);
    chk("small_7_blank", s_blank, 3'b110);
    conv_small(100);
    chk("small_100", s_bcd, 12'h100);
    for (int v = 0; v < 256; v++) begin
      conv_small(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
